// File: rtl/movegen_pkg.sv
// Shared types for the move-generation sequencer and its helpers.
package movegen_pkg;

    localparam int NUM_SQ = 64;

    typedef logic [5:0] sq_t;

    typedef struct packed {
        sq_t from;
        sq_t to;
    } move_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EMIT   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // Board coordinates (rank 1..8, file 1..8) to square index; a1=0, h8=63.
    function automatic sq_t sq_index(input int unsigned rank, input int unsigned file);
        return sq_t'((rank - 1) * 8 + (file - 1));
    endfunction

endpackage

// File: rtl/lsb_onehot_enc.sv
// Lowest-set-bit encoder: index, any-set flag and one-hot of the lowest set bit.
module lsb_onehot_enc
    import movegen_pkg::*;
(
    input  logic [NUM_SQ-1:0] i_vec,
    output sq_t               o_idx,
    output logic              o_any,
    output logic [NUM_SQ-1:0] o_onehot
);

    assign o_any    = |i_vec;
    // x & -x isolates the lowest set bit.
    assign o_onehot = i_vec & (~i_vec + NUM_SQ'(1));

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_SQ - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = sq_t'(i);
        end
    end

endmodule

// File: rtl/movegen_sequencer.sv
// Scans the side-to-move's pieces, strobes each square into the array and
// streams the resulting (from, to) pairs out, lowest index first.
module movegen_sequencer
    import movegen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [NUM_SQ-1:0] i_own,
    output logic [NUM_SQ-1:0] o_emit_move,
    input  logic [NUM_SQ-1:0] i_target,
    output logic              o_move_valid,
    input  logic              i_move_ready,
    output sq_t               o_move_from,
    output sq_t               o_move_to,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_move_count
);

    seq_state_t        state_q, state_d;
    logic [NUM_SQ-1:0] pending_q, pending_d;
    logic [NUM_SQ-1:0] tgt_q, tgt_d;
    sq_t               from_q, from_d;
    logic [CNT_W-1:0]  count_q, count_d;

    sq_t               pend_idx, tgt_idx;
    logic              pend_any, tgt_any;
    logic [NUM_SQ-1:0] pend_onehot, tgt_onehot;
    logic [NUM_SQ-1:0] tgt_left;
    move_t             cur_move;

    lsb_onehot_enc u_pend_enc (
        .i_vec    (pending_q),
        .o_idx    (pend_idx),
        .o_any    (pend_any),
        .o_onehot (pend_onehot)
    );

    lsb_onehot_enc u_tgt_enc (
        .i_vec    (tgt_q),
        .o_idx    (tgt_idx),
        .o_any    (tgt_any),
        .o_onehot (tgt_onehot)
    );

    assign tgt_left = tgt_q & ~tgt_onehot;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers; all reset so outputs decode to known values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            tgt_q     <= '0;
            from_q    <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            tgt_q     <= tgt_d;
            from_q    <= from_d;
            count_q   <= count_d;
        end
    end

    // Next-state and datapath updates; abort overrides every transition.
    always_comb begin
        // NOTE: hold-value defaults first so no path through the case infers a latch.
        state_d   = state_q;
        pending_d = pending_q;
        tgt_d     = tgt_q;
        from_d    = from_q;
        count_d   = count_q;
        if (i_abort) begin
            state_d   = IDLE;
            pending_d = '0;
            tgt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        pending_d = i_own;
                        count_d   = '0;
                        state_d   = SELECT;
                    end
                end
                SELECT: begin
                    if (!pend_any) begin
                        state_d = DONE;
                    end else begin
                        from_d    = pend_idx;
                        pending_d = pending_q & ~pend_onehot;
                        state_d   = EMIT;
                    end
                end
                EMIT: begin
                    tgt_d   = i_target;
                    state_d = (|i_target) ? DRAIN : SELECT;
                end
                DRAIN: begin
                    if (i_move_ready) begin
                        tgt_d = tgt_left;
                        if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
                        if (tgt_left == '0) state_d = SELECT;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only; nothing sees i_move_ready.
    always_comb begin
        cur_move.from = from_q;
        cur_move.to   = tgt_idx;
        o_emit_move   = (state_q == EMIT) ? (NUM_SQ'(1) << from_q) : '0;
        o_move_valid  = (state_q == DRAIN) && tgt_any;
        o_move_from   = cur_move.from;
        o_move_to     = cur_move.to;
        o_busy        = (state_q != IDLE);
        o_done        = (state_q == DONE);
        o_move_count  = count_q;
    end

endmodule
